// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: multi-cycle add/sub/shift-add mul/restoring div sequencer
module calc_alu_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  alu_op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] b_q, b_d, result_q, result_d;
    logic [63:0] mc_q, mc_d, acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dz_q, dz_d;
    logic [32:0] rem_shift, trial;
    logic        last;

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;
    assign div_zero = dz_q;

    // mc holds the multiplicand (shifted left) for mul and the dividend (shifted out MSB first) for div
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        mc_d      = mc_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        rem_shift = {acc_q[63:32], mc_q[31]};
        trial     = rem_shift - {1'b0, b_q};
        last      = (cnt_q == 5'd0) || !op_q[1] || (op_q == 2'd3 && b_q == 32'd0);
        if (state_q == RUN) begin
            if (op_q == 2'd2) begin
                acc_d = acc_q + (b_q[0] ? mc_q : 64'd0);
                mc_d  = mc_q << 1;
                b_d   = b_q >> 1;
            end else if (op_q == 2'd3) begin
                acc_d = {trial[32] ? rem_shift[31:0] : trial[31:0], acc_q[30:0], ~trial[32]};
                mc_d  = mc_q << 1;
            end
            cnt_d = cnt_q - 5'd1;
            if (last) begin
                state_d  = DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = op_q == 2'd0 ? mc_q[31:0] + b_q :
                           op_q == 2'd1 ? mc_q[31:0] - b_q :
                           (op_q == 2'd3 && b_q == 32'd0) ? 32'd0 : acc_d[31:0];
                ovf_d    = op_q == 2'd2 && |acc_d[63:32];
                dz_d     = op_q == 2'd3 && b_q == 32'd0;
            end
        end else if (start) begin
            state_d = RUN;
            busy_d  = 1'b1;
            op_d    = alu_op;
            b_d     = operand_b;
            mc_d    = {32'd0, operand_a};
            acc_d   = 64'd0;
            cnt_d   = 5'd31;
            ovf_d   = 1'b0;
            dz_d    = 1'b0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            b_q      <= 32'd0;
            mc_q     <= 64'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            mc_q     <= mc_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end
endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb_calc_alu_sequencer: randomized and directed checks against an arithmetic reference model
module tb_calc_alu_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  alu_op = 2'd0;
    logic [31:0] operand_a = 32'd0, operand_b = 32'd0;
    logic        busy, done, overflow, div_zero;
    logic [31:0] result;
    int          passed = 0, total = 0;

    calc_alu_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .alu_op(alu_op),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
        .result(result), .overflow(overflow), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ov, output logic dz, output int n);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        ov = 1'b0; dz = 1'b0; n = 1;
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: begin r = p[31:0]; ov = |p[63:32]; n = 32; end
            default: if (b == 0) begin r = 0; dz = 1'b1; end else begin r = a / b; n = 32; end
        endcase
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        alu_op = op; operand_a = a; operand_b = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        alu_op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (busy) cycles++;
            @(negedge clock);
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er; logic eov, edz; int en, cyc; bit ok;
        model(op, a, b, er, eov, edz, en);
        issue(op, a, b);
        wait_done(cyc, ok);
        total++;
        if (!ok) $display("FAIL %s timeout: no done within 100 cycles", name);
        else passed++;
        total++;
        if (cyc !== en) $display("FAIL %s busy_cycles got %0d expected %0d", name, cyc, en);
        else passed++;
        total++;
        if ({result, overflow, div_zero} !== {er, eov, edz})
            $display("FAIL %s result got %h ov=%b dz=%b expected %h ov=%b dz=%b", name, result, overflow, div_zero, er, eov, edz);
        else passed++;
        @(negedge clock);
        total++;
        if ({done, busy, result} !== {1'b0, 1'b0, er})
            $display("FAIL %s after_done got done=%b busy=%b result=%h expected 0 0 %h", name, done, busy, result, er);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({busy, done, result, overflow, div_zero} !== 35'd0)
            $display("FAIL reset got busy=%b done=%b result=%h ov=%b dz=%b expected all 0", busy, done, result, overflow, div_zero);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_check("add", 2'd0, 32'd123, 32'd877);
        run_check("sub_wrap", 2'd1, 32'd3, 32'd5);
        run_check("mul_ovf", 2'd2, 32'h0001_0000, 32'h0001_0000);
        run_check("mul", 2'd2, 32'd1234, 32'd5678);
        run_check("div", 2'd3, 32'd100, 32'd7);
        run_check("div_max", 2'd3, 32'hFFFF_FFFF, 32'd1);
        run_check("div_zero", 2'd3, 32'd5, 32'd0);
        run_check("mul_max", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op; logic [31:0] a, b;
            op = 2'($urandom); a = $urandom;
            b = (i % 6 == 5) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_check($sformatf("rand%0d", i), op, a, b);
        end
    endtask

    task automatic test_start_busy();
        int cyc, pulses; bit ok;
        issue(2'd2, 32'd12, 32'd12);
        repeat (9) @(negedge clock);
        alu_op = 2'd0; operand_a = 32'd1; operand_b = 32'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc, ok);
        total++;
        if (!ok || 10 + cyc != 32 || result !== 32'd144)
            $display("FAIL start_busy got ok=%b busy_cycles=%0d result=%0d expected 1 32 144", ok, 10 + cyc, result);
        else passed++;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0 || busy !== 1'b0) $display("FAIL start_busy_extra got pulses=%0d busy=%b expected 0 0", pulses, busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok;
        issue(2'd3, 32'd5, 32'd0);
        wait_done(cyc, ok);
        total++;
        if (!ok || div_zero !== 1'b1) $display("FAIL b2b_first got ok=%b dz=%b expected 1 1", ok, div_zero);
        else passed++;
        alu_op = 2'd1; operand_a = 32'd9; operand_b = 32'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        total++;
        if ({busy, done, div_zero, overflow} !== 4'b1000)
            $display("FAIL b2b_accept got busy=%b done=%b dz=%b ov=%b expected 1 0 0 0", busy, done, div_zero, overflow);
        else passed++;
        wait_done(cyc, ok);
        total++;
        if (!ok || cyc != 1 || result !== 32'd5 || div_zero !== 1'b0)
            $display("FAIL b2b_result got ok=%b cycles=%0d result=%0d dz=%b expected 1 1 5 0", ok, cyc, result, div_zero);
        else passed++;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int pulses;
        run_check("pre_mid", 2'd2, 32'h1000_0000, 32'h100);
        issue(2'd3, 32'd1000, 32'd3);
        repeat (15) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({busy, done, result, overflow, div_zero} !== 35'd0)
            $display("FAIL reset_mid got busy=%b done=%b result=%h ov=%b dz=%b expected all 0", busy, done, result, overflow, div_zero);
        else passed++;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL reset_mid_idle got %0d active cycles expected 0", pulses);
        else passed++;
        run_check("div_after_reset", 2'd3, 32'd1000, 32'd3);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/calc_alu_sequencer.md
# calc_alu_sequencer

Multi-cycle arithmetic sequencer for the calculator datapath. Accepts an operation code and two 32-bit unsigned operands from the keypad controller on a start strobe, executes add/sub in one iteration and mul/div as 32-iteration shift-add and restoring-divide loops, then returns a registered result with a one-cycle done pulse. It replaces the single-cycle `*` and `/` in the controller's evaluate path, so the controller waits on `done` instead of computing inline.

## Interface

Parameters:
- none; operand and result width fixed at 32 bits, iteration count fixed at 32.

Ports:
- clock  in  1  positive-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when `busy`=0
- alu_op  in  2  0=add, 1=sub, 2=mul, 3=div
- operand_a  in  32  first operand (operandF), unsigned
- operand_b  in  32  second operand (operandS), unsigned
- busy  out  1  high while an operation is executing
- done  out  1  one-cycle pulse; result and flags valid
- result  out  32  registered result, held until the next accepted start
- overflow  out  1  mul product ≥ 2^32 (result = low 32 bits)
- div_zero  out  1  div with operand_b = 0

## Operation

- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch alu_op, operand_a, operand_b; clear overflow and div_zero; load iteration counter; go to RUN; busy=1.
- IDLE/DONE with start=0: go to or stay in IDLE; done=0.
- RUN, add: result = (a + b) mod 2^32; one iteration; no flags.
- RUN, sub: result = (a − b) mod 2^32 (two's-complement wrap, e.g. 3−5 = 0xFFFF_FFFE); one iteration.
- RUN, mul: unsigned shift-add, one multiplier bit per cycle, LSB first, 64-bit accumulator; 32 iterations; result = acc[31:0]; overflow = |acc[63:32].
- RUN, div: restoring division, one quotient bit per cycle, MSB first; 32 iterations; result = quotient (remainder discarded, truncating).
- RUN, div with b=0: one iteration; result=0; div_zero=1; no loop executed.
- After the last iteration: go to DONE; done=1 and busy=0 for exactly that cycle; result/flags updated on that same edge.
- start while busy=1: ignored, not queued.
- alu_op, operand_a, operand_b may change freely after acceptance; only latched copies are used.

## Timing

- Reset (synchronous, edge-sampled): state=IDLE, busy=0, done=0, result=0, overflow=0, div_zero=0, counter=0, internal operand registers=0.
- Start accepted at edge E0 → busy=1 from E0.
- N = 1 for add, sub, div-by-zero; N = 32 for mul and div (b≠0).
- Iterations occur at edges E1..EN; after EN: done=1, busy=0, result valid.
- Latency start-edge to done: N+1 cycles... measured as edges E0→EN, i.e. N cycles of busy, then done visible in the cycle after EN.
- DONE lasts one cycle; at EN+1 the block goes to IDLE, or back to RUN if start=1 (back-to-back, no bubble beyond DONE).
- Reset during RUN or DONE: abort, no done pulse, all outputs return to reset values on that edge; reset dominates start.
- result, overflow, div_zero hold their values through IDLE until the next accepted start clears the flags (result changes only at the final iteration edge).

## Test plan

- Reset then add: a=123, b=877, op=0, start 1 cycle → busy 1 cycle, done pulse one cycle later, result=1000, flags 0.
- Sub wrap and mul overflow: a=3, b=5, op=1 → result=0xFFFF_FFFE after 1 iteration; a=0x0001_0000, b=0x0001_0000, op=2 → done after 32 busy cycles, result=0, overflow=1; a=1234, b=5678, op=2 → result=7006652, overflow=0.
- Divide: a=100, b=7, op=3 → 32 busy cycles, result=14; a=0xFFFF_FFFF, b=1 → result=0xFFFF_FFFF; a=5, b=0 → 1 busy cycle, result=0, div_zero=1.
- Start during busy: accept mul 12×12, pulse start with op=0 at cycle 10 → ignored; done at cycle 32 with result=144, exactly one done pulse.
- Back-to-back: assert start in the DONE cycle with a=9, b=4, op=1 → accepted, busy next cycle, result=5; previous flags cleared at acceptance.
- Reset mid-divide: accept 1000/3, assert reset at busy cycle 16 → busy=0, done never pulses, result=0, all flags 0; subsequent 1000/3 returns 333.
